// File: rtl/bit_packer_pkg.sv
// -----------------------------------------------------------------------------
// bit_packer_pkg
// Shared types and constants for the bit_packer block.
//   state_t      : packer FSM states (ACC, STUFF, DRAIN)
//   ACC_W_DEF    : default accumulator width in bits
//   MAX_LEN_DEF  : default maximum code length per input beat
//   PAD_ONES     : fill pattern used when a flush pads to a byte boundary
//   STUFF_MARK   : byte value that triggers a 0x00 stuff byte when enabled
// -----------------------------------------------------------------------------
package bit_packer_pkg;

  localparam int         ACC_W_DEF   = 64;
  localparam int         MAX_LEN_DEF = 32;
  localparam logic [7:0] PAD_ONES    = 8'hFF;
  localparam logic [7:0] STUFF_MARK  = 8'hFF;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_STUFF = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bit_packer.sv
// -----------------------------------------------------------------------------
// bit_packer
// Packs variable-length codes (right-aligned, emitted MSB-first) into a byte
// stream. Pending bits sit MSB-aligned in acc; a flush pads the stream with
// one-bits up to a byte boundary, drains it and pulses flush_done.
//
// Optional feature: define BIT_PACKER_STUFF_EN to insert a 0x00 byte after
// every emitted 0xFF byte (JPEG byte stuffing).
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   code, code_len    : code bits (low code_len bits used) and their count
//   code_flush        : pad to a byte boundary after this beat, then drain
//   code_vld/code_rdy : input beat handshake
//   dout, dout_vld    : packed output byte and its valid
//   dout_rdy          : downstream ready
//   flush_done        : one-cycle pulse when a flush has fully drained
//
// Handshake: a beat/byte transfers on a rising edge where valid and ready are
// both high. code_rdy depends only on registers; dout/dout_vld stay stable
// while dout_rdy is low.
// -----------------------------------------------------------------------------
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] code,
  input  logic [LEN_W-1:0]   code_len,
  input  logic               code_flush,
  input  logic               code_vld,
  output logic               code_rdy,
  output logic [7:0]         dout,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               flush_done
);

  // Accept only while a full-length beat plus worst-case padding still fits.
  localparam logic [6:0] RDY_LIMIT = 7'(ACC_W - MAX_LEN - 8);
  localparam logic [6:0] ACC_W7    = 7'(ACC_W);
  localparam logic [6:0] MAX_LEN7  = 7'(MAX_LEN);

  state_t           state, state_nxt;
  state_t           ret_state, ret_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_base;
  logic [ACC_W-1:0] code_ext, code_mask, pad_bits, chunk;
  logic [6:0]       cnt, cnt_nxt, cnt_base;
  logic [6:0]       len7, sum7, tot7;
  logic [3:0]       pad;
  logic             accept, emit, stuff_hit;

  assign code_rdy   = (state == ST_ACC) && (cnt <= RDY_LIMIT);
  assign accept     = code_vld && code_rdy;
  assign dout       = (state == ST_STUFF) ? 8'h00 : acc[ACC_W-1 -: 8];
  assign dout_vld   = (state == ST_STUFF) ? 1'b1 : (cnt >= 7'd8);
  assign emit       = (state != ST_STUFF) && dout_vld && dout_rdy;
  assign flush_done = (state == ST_DRAIN) && (cnt == 7'd0);

`ifdef BIT_PACKER_STUFF_EN
  assign stuff_hit = emit && (dout == STUFF_MARK);
`else
  assign stuff_hit = 1'b0;
`endif

  // Datapath: the emitted byte leaves first, then the new code (and any
  // flush padding) is appended directly below the remaining pending bits.
  always_comb begin
    acc_base  = emit ? (acc << 8) : acc;
    cnt_base  = emit ? (cnt - 7'd8) : cnt;
    len7      = (7'(code_len) > MAX_LEN7) ? MAX_LEN7 : 7'(code_len);
    code_ext  = ACC_W'(code);
    code_mask = (ACC_W'(1) << len7) - ACC_W'(1);
    sum7      = cnt_base + len7;
    // (8 - n%8) % 8 equals (-n) mod 8, i.e. the 3-bit negation of n.
    pad       = code_flush ? {1'b0, 3'd0 - sum7[2:0]} : 4'd0;
    pad_bits  = ACC_W'(PAD_ONES >> (4'd8 - pad));
    chunk     = ((code_ext & code_mask) << pad) | pad_bits;
    tot7      = sum7 + 7'(pad);
    acc_nxt   = acc_base;
    cnt_nxt   = cnt_base;
    if (accept) begin
      acc_nxt = acc_base | (chunk << (ACC_W7 - tot7));
      cnt_nxt = tot7;
    end
  end

  // Next-state logic. A 0xFF emitted in the same cycle as a flush accept
  // must come back to DRAIN after the stuff byte, not to ACC.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    case (state)
      ST_ACC: begin
        if (stuff_hit) begin
          state_nxt = ST_STUFF;
          ret_nxt   = (accept && code_flush) ? ST_DRAIN : ST_ACC;
        end else if (accept && code_flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (stuff_hit) begin
          state_nxt = ST_STUFF;
          ret_nxt   = ST_DRAIN;
        end else if (cnt == 7'd0) begin
          state_nxt = ST_ACC;
        end
      end
      ST_STUFF: begin
        if (dout_rdy) state_nxt = ret_state;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      ret_state <= ST_ACC;
      acc       <= '0;
      cnt       <= 7'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL have parameter ACC_W, default 64, accumulator width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum code length per beat.
REQ-003 SHALL have parameter LEN_W, default 6, width of code_len.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port code  input  MAX_LEN  code bits, right-aligned, emitted MSB-first.
REQ-007 SHALL have port code_len  input  LEN_W  number of valid code bits, 0..MAX_LEN.
REQ-008 SHALL have port code_flush  input  1  pad to a byte boundary after this beat and drain.
REQ-009 SHALL have port code_vld  input  1  input beat valid.
REQ-010 SHALL have port code_rdy  output  1  input beat accepted when high with code_vld.
REQ-011 SHALL have port dout  output  8  packed output byte.
REQ-012 SHALL have port dout_vld  output  1  output byte valid.
REQ-013 SHALL have port dout_rdy  input  1  downstream ready (byte FIFO din_rdy).
REQ-014 SHALL have port flush_done  output  1  one-cycle pulse when a flush has fully drained.

Function
REQ-015 SHALL hold pending bits MSB-aligned in acc[ACC_W-1:0], with count cnt (7 bits, 0..ACC_W).
REQ-016 SHALL, on accept (code_vld&code_rdy), append the low code_len bits of code below the pending bits; bits above code_len are ignored.
REQ-017 SHALL saturate code_len > MAX_LEN to MAX_LEN.
REQ-018 SHALL treat code_len=0 without flush as an accepted no-op.
REQ-019 SHALL, on accept with code_flush=1, append (8-(cnt+len)%8)%8 one-bits after the code, then enter DRAIN.
REQ-020 SHALL drive dout=acc[ACC_W-1:ACC_W-8] and dout_vld=(cnt>=8) in ACC/DRAIN, dout=0x00 and dout_vld=1 in STUFF.
REQ-021 SHALL, on dout_vld&dout_rdy in ACC/DRAIN, shift acc left by 8 and subtract 8 from cnt.
REQ-022 SHALL allow accept and emit in the same cycle: cnt_next = cnt + len + pad - (emit ? 8 : 0).
REQ-023 SHALL drive code_rdy = (state==ACC) & (cnt <= ACC_W-MAX_LEN-8); this is purely a function of registers.
REQ-024 SHALL have latency one cycle: a byte completed by an accept at edge N has dout_vld high from edge N onward.
REQ-025 SHALL hold dout and dout_vld stable while dout_rdy is low.
REQ-026 SHALL implement the FSM ACC, STUFF, DRAIN: ACC->DRAIN on a flush accept; DRAIN->ACC when cnt==0 and no stuff is pending, pulsing flush_done that cycle; ACC/DRAIN->STUFF per REQ-033; STUFF->return state on dout_rdy.
REQ-027 SHALL raise flush_done for a flush with zero pending bits one cycle after the accept.

Reset
REQ-028 SHALL, on rst assertion, immediately clear acc, cnt, state=ACC, return state and flush_done, discarding pending bits.
REQ-029 SHALL drive dout_vld=0, dout=0x00, flush_done=0 and code_rdy=1 while in reset and after release.
REQ-030 SHALL begin a fresh bitstream after a reset asserted mid-operation, with no residual bits.

Configuration
REQ-031 SHALL compile JPEG byte stuffing in only when macro BIT_PACKER_STUFF_EN is defined.
REQ-032 SHALL, without BIT_PACKER_STUFF_EN, never enter STUFF; 0xFF bytes are emitted unmodified.
REQ-033 SHALL, with BIT_PACKER_STUFF_EN, on acceptance of an emitted 0xFF byte, save the return state, enter STUFF, and emit 0x00 next; code_rdy stays low in STUFF.

Structure
REQ-034 SHALL place the FSM state enum, ACC_W/MAX_LEN defaults and the pad-one constant in package bit_packer_pkg.
REQ-035 SHALL be one flat module with no sub-module; its output connects directly to a basic_fifo input.

Verification
REQ-036 SHALL cover: code=0x5 len=3, then code=0x1F len=5 -> single byte 0xBF, cnt=0.
REQ-037 SHALL cover: code=0xFF len=8 -> 0xFF,0x00 with BIT_PACKER_STUFF_EN; 0xFF only without it.
REQ-038 SHALL cover: code=0x2 len=2 flush=1 -> byte 0xBF, then flush_done one-cycle pulse, code_rdy low until done.
REQ-039 SHALL cover: dout_rdy=0 with codes 0x01..0x05 len=8 -> exactly 4 accepted (code_rdy low at cnt=32); after release, bytes 0x01,0x02,0x03,0x04 in order, then 0x05 accepted.
REQ-040 SHALL cover: rst pulsed with cnt=16 -> dout_vld=0 immediately; next code 0xA5 len=8 -> 0xA5 only.
REQ-041 SHALL cover: code_len=40 code=0xFFFFFFFF -> treated as len 32, four 0xFF bytes (stuffed per config).
